// File: rtl/spi_bus_bridge.sv
// SPI mode-0 slave that turns 2-byte frames ({rw, addr[6:0]}, data) into single-cycle
// writes or register reads on the pwm 8-bit register bus. SPI pins are oversampled on clk_i.
module spi_bus_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_sck_i,
  input  logic       spi_cs_n_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic [7:0] b_addr_o,
  output logic [7:0] b_data_o,
  input  logic [7:0] b_data_i,
  output logic       b_write_o,
  output logic       frame_err_o
);

  typedef enum logic [2:0] {IDLE, CMD, RDCAP, DATA, DONE} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             cmd_sr_q, cmd_sr_d;
  logic [6:0]             rx_sr_q, rx_sr_d;
  logic [7:0]             tx_sr_q, tx_sr_d;
  logic                   rw_q, rw_d;
  logic [7:0]             b_addr_q, b_addr_d;
  logic [7:0]             b_data_q, b_data_d;
  logic                   b_write_q, b_write_d;
  logic                   frame_err_q, frame_err_d;

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;

  // CS synchronizer resets low so a CS already low at reset release never looks like a fall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_sr_d    = cmd_sr_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    rw_d        = rw_q;
    b_addr_d    = b_addr_q;
    b_data_d    = b_data_q;
    b_write_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = CMD;
          bit_cnt_d = '0;
          cmd_sr_d  = '0;
          rx_sr_d   = '0;
        end
      end
      CMD: begin
        if (sck_rise) begin
          cmd_sr_d  = {cmd_sr_q[5:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            rw_d     = cmd_sr_q[6];
            b_addr_d = {1'b0, cmd_sr_q[5:0], mosi_s};
            state_d  = cmd_sr_q[6] ? RDCAP : DATA;
          end
        end
      end
      RDCAP: begin
        tx_sr_d = b_data_i;
        state_d = DATA;
      end
      DATA: begin
        if (sck_rise) begin
          rx_sr_d   = {rx_sr_q[5:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd15) begin
            state_d = DONE;
            if (!rw_q) begin
              b_data_d  = {rx_sr_q, mosi_s};
              b_write_d = 1'b1;
            end
          end
        end else if (sck_fall && rw_q && bit_cnt_q != 5'd8) begin
          // The fall before the first data rise keeps MSB on MISO.
          tx_sr_d = {tx_sr_q[6:0], 1'b0};
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
    // CS rise is applied after the SCK edge of the same cycle, so a completing frame still writes.
    if (cs_rise) begin
      if (state_d == CMD || state_d == RDCAP || state_d == DATA) frame_err_d = 1'b1;
      state_d   = IDLE;
      bit_cnt_d = '0;
      cmd_sr_d  = '0;
      rx_sr_d   = '0;
      tx_sr_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      cmd_sr_q    <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      rw_q        <= 1'b0;
      b_addr_q    <= '0;
      b_data_q    <= '0;
      b_write_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_sr_q    <= cmd_sr_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      rw_q        <= rw_d;
      b_addr_q    <= b_addr_d;
      b_data_q    <= b_data_d;
      b_write_q   <= b_write_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign spi_miso_o  = (state_q == DATA && rw_q) ? tx_sr_q[7] : 1'b0;
  assign b_addr_o    = b_addr_q;
  assign b_data_o    = b_data_q;
  assign b_write_o   = b_write_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Directed bench for spi_bus_bridge: SPI master driver, bus write scoreboard,
// read-data capture from MISO and frame-error counting.
module tb_spi_bus_bridge;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       spi_sck_i = 1'b0;
  logic       spi_cs_n_i = 1'b1;
  logic       spi_mosi_i = 1'b0;
  logic       spi_miso_o;
  logic [7:0] b_addr_o;
  logic [7:0] b_data_o;
  logic [7:0] b_data_i;
  logic       b_write_o;
  logic       frame_err_o;

  int total = 0;
  int bad = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          wr_cnt = 0;
  int          err_cnt = 0;
  int          wr_run = 0;
  int          wr_run_max = 0;
  int          miso_hi = 0;
  logic [7:0]  rd_bits;

  spi_bus_bridge #(.SYNC_STAGES(2)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .spi_sck_i   (spi_sck_i),
    .spi_cs_n_i  (spi_cs_n_i),
    .spi_mosi_i  (spi_mosi_i),
    .spi_miso_o  (spi_miso_o),
    .b_addr_o    (b_addr_o),
    .b_data_o    (b_data_o),
    .b_data_i    (b_data_i),
    .b_write_o   (b_write_o),
    .frame_err_o (frame_err_o)
  );

  // Clock / reset.
  always #5 clk_i = ~clk_i;

  // Register file model of pwm: only 0x01 returns a non-zero value.
  assign b_data_i = (b_addr_o == 8'h01) ? 8'h5A : 8'h00;

  // Bus monitor, sampled away from the active edge.
  always @(negedge clk_i) begin
    if (b_write_o) begin
      obs_q.push_back({b_addr_o, b_data_o});
      wr_cnt++;
      wr_run++;
      if (wr_run > wr_run_max) wr_run_max = wr_run;
    end else begin
      wr_run = 0;
    end
    if (frame_err_o) err_cnt++;
    if (spi_miso_o) miso_hi++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  // One SPI transaction; nbits may be short (aborted) or long (extra clocks).
  task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1, input int nbits,
                           input int half, input bit keep_cs);
    logic [15:0] word;
    word = {b0, b1};
    spi_cs_n_i = 1'b0;
    wait_clk(half);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi_i = (i < 16) ? word[15-i] : i[0];
      wait_clk(half);
      if (i >= 8 && i < 16) rd_bits[15-i] = spi_miso_o;
      spi_sck_i = 1'b1;
      wait_clk(half);
      spi_sck_i = 1'b0;
    end
    wait_clk(half);
    if (!keep_cs) begin
      spi_cs_n_i = 1'b1;
      wait_clk(half);
    end
  endtask

  task automatic check_writes(input string tag);
    logic [15:0] e, o;
    check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check_eq({tag, "_addr_data"}, o, e);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    int w0, e0;
    wait_clk(4);
    check_eq("rst_miso", spi_miso_o, 0);
    check_eq("rst_addr", b_addr_o, 0);
    check_eq("rst_data", b_data_o, 0);
    check_eq("rst_write", b_write_o, 0);
    check_eq("rst_ferr", frame_err_o, 0);
    rst_i = 1'b0;
    wait_clk(10);

    // 1: two writes
    miso_hi = 0;
    exp_q.push_back(16'h0082);
    exp_q.push_back(16'h0101);
    spi_frame(8'h00, 8'h82, 16, 6, 0);
    spi_frame(8'h01, 8'h01, 16, 6, 0);
    wait_clk(4);
    check_writes("t1");
    check_eq("t1_pulse_width", wr_run_max, 1);
    check_eq("t1_miso_idle", miso_hi, 0);

    // 2: read of 0x01
    w0 = wr_cnt;
    rd_bits = 8'h00;
    spi_frame(8'h81, 8'h00, 16, 6, 0);
    wait_clk(4);
    check_eq("t2_miso_bits", rd_bits, 8'h5A);
    check_eq("t2_no_write", wr_cnt, w0);
    check_eq("t2_addr", b_addr_o, 8'h01);
    check_eq("t2_data_held", b_data_o, 8'h01);

    // 3: aborted after 11 bits, then a normal frame
    w0 = wr_cnt;
    e0 = err_cnt;
    spi_frame(8'h03, 8'hAA, 11, 6, 0);
    wait_clk(4);
    check_eq("t3_err_pulse", err_cnt, e0 + 1);
    check_eq("t3_no_write", wr_cnt, w0);
    exp_q.push_back(16'h0455);
    spi_frame(8'h04, 8'h55, 16, 6, 0);
    wait_clk(4);
    check_writes("t3");
    check_eq("t3_no_err_full", err_cnt, e0 + 1);

    // 4: 20 SCK cycles, one write only
    e0 = err_cnt;
    exp_q.push_back(16'h053C);
    spi_frame(8'h05, 8'h3C, 20, 6, 0);
    wait_clk(4);
    check_writes("t4");
    check_eq("t4_no_err", err_cnt, e0);

    // 5: reset at bit 12 of a write
    e0 = err_cnt;
    w0 = wr_cnt;
    spi_frame(8'h06, 8'h77, 12, 6, 1);
    rst_i = 1'b1;
    #1;
    check_eq("t5_addr_cleared", b_addr_o, 0);
    check_eq("t5_data_cleared", b_data_o, 0);
    check_eq("t5_write_low", b_write_o, 0);
    wait_clk(3);
    rst_i = 1'b0;
    wait_clk(3);
    for (int i = 0; i < 6; i++) begin
      spi_mosi_i = 1'b1;
      spi_sck_i = 1'b1;
      wait_clk(6);
      spi_sck_i = 1'b0;
      wait_clk(6);
    end
    spi_cs_n_i = 1'b1;
    wait_clk(8);
    check_eq("t5_no_write", wr_cnt, w0);
    check_eq("t5_no_err", err_cnt, e0);
    exp_q.push_back(16'h02FF);
    spi_frame(8'h02, 8'hFF, 16, 6, 0);
    wait_clk(4);
    check_writes("t5");

    // 6: back-to-back at minimum timing
    exp_q.push_back(16'h0711);
    exp_q.push_back(16'h0822);
    spi_frame(8'h07, 8'h11, 16, 5, 0);
    spi_frame(8'h08, 8'h22, 16, 5, 0);
    wait_clk(6);
    check_writes("t6");
    check_eq("t6_pulse_width", wr_run_max, 1);
    check_eq("t6_no_err", err_cnt, e0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
